// File: rtl/final_project_soc_keys.sv
`default_nettype none
// ============================================================================
// final_project_soc_keys : Avalon-MM PIO input port with edge capture + IRQ
// Revision 1.0
// ============================================================================
module final_project_soc_keys #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = &{1'b0, writedata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
      assign w_deb = r_sync2;
    end else begin : g_deb
      localparam logic [15:0] c_DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [15:0] r_cnt;
        logic        r_deb;
        // Counter only runs while the synchronized input disagrees with deb.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
          end else if (r_sync2[i] == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_cnt <= '0;
            r_deb <= r_sync2[i];
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        assign w_deb[i] = r_deb;
      end
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       w_edge = w_deb & ~r_prev;
      1:       w_edge = ~w_deb & r_prev;
      default: w_edge = (w_deb & ~r_prev) | (~w_deb & r_prev);
    endcase
  end

  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge is OR-ed in after the clear so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
      r_cap  <= '0;
      r_mask <= '0;
    end else begin
      r_prev <= w_deb;
      r_cap  <= (r_cap & ~w_clr) | w_edge;
      if (w_wr && address == 2'd2) begin
        r_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(r_cap & r_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = w_deb;
      2'd2:    readdata[WIDTH-1:0] = r_mask;
      2'd3:    readdata[WIDTH-1:0] = r_cap;
      default: readdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_final_project_soc_keys.sv
`default_nettype none
// ============================================================================
// tb_final_project_soc_keys : directed scoreboard bench for the PIO input port
// Revision 1.0
// ============================================================================
module tb_final_project_soc_keys;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic [3:0]  cs;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_r, in_d, in_a, in_f;
  logic [31:0] rd_r, rd_d, rd_a, rd_f;
  logic        irq_r, irq_d, irq_a, irq_f;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          idx;
    logic        is_irq;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  always #10 clk = ~clk;

  final_project_soc_keys #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_r (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write_n(write_n),
    .writedata(writedata), .in_port(in_r), .readdata(rd_r), .irq(irq_r));
  final_project_soc_keys #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(8)) u_d (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write_n(write_n),
    .writedata(writedata), .in_port(in_d), .readdata(rd_d), .irq(irq_d));
  final_project_soc_keys #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));
  final_project_soc_keys #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0)) u_f (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write_n(write_n),
    .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f));

  function automatic logic [31:0] obs_of(input int idx, input logic is_irq);
    case (idx)
      0:       return is_irq ? {31'b0, irq_r} : rd_r;
      1:       return is_irq ? {31'b0, irq_d} : rd_d;
      2:       return is_irq ? {31'b0, irq_a} : rd_a;
      default: return is_irq ? {31'b0, irq_f} : rd_f;
    endcase
  endfunction

  task automatic compare_pop();
    exp_t        x;
    logic [31:0] obs;
    x   = sb.pop_front();
    obs = obs_of(x.idx, x.is_irq);
    checks++;
    assert (obs === x.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int idx, input logic [1:0] a, input logic [31:0] e);
    sb.push_back('{tag, idx, 1'b0, e});
    address = a;
    #1;
    compare_pop();
  endtask

  task automatic chk_irq(input string tag, input int idx, input logic e);
    sb.push_back('{tag, idx, 1'b1, {31'b0, e}});
    #1;
    compare_pop();
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] sel, input logic [1:0] a, input logic [31:0] d);
    cs        = sel;
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    cs      = 4'b0;
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; cs = 4'b0; write_n = 1'b1; writedata = '0;
    in_r = 4'h0; in_d = 4'h0; in_a = 4'h0; in_f = 4'h0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Build up live state, then assert reset mid-cycle with inputs high.
    wr(4'b0001, 2'd2, 32'hF);
    in_r = 4'hF;
    tick(4);
    chk_rd("pre_rst_cap", 0, 2'd3, 32'hF);
    chk_irq("pre_rst_irq", 0, 1'b1);
    #3;
    reset = 1'b1;
    chk_rd("rst_a0", 0, 2'd0, 32'h0);
    chk_rd("rst_a1", 0, 2'd1, 32'h0);
    chk_rd("rst_a2", 0, 2'd2, 32'h0);
    chk_rd("rst_a3", 0, 2'd3, 32'h0);
    chk_irq("rst_irq", 0, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(1);
    chk_rd("rel_e1_data", 0, 2'd0, 32'h0);
    tick(1);
    chk_rd("rel_e2_data", 0, 2'd0, 32'hF);
    chk_rd("rel_e2_cap", 0, 2'd3, 32'h0);
    tick(1);
    chk_rd("rel_e3_cap", 0, 2'd3, 32'hF);
    chk_irq("rel_irq", 0, 1'b0);
    wr(4'b0001, 2'd3, 32'hF);
    chk_rd("rel_clr", 0, 2'd3, 32'h0);

    // Falling edges are ignored by the rising-capture instance.
    in_r = 4'h0;
    tick(3);
    chk_rd("fall_ignored", 0, 2'd3, 32'h0);

    // Rising capture with no debounce.
    wr(4'b0001, 2'd2, 32'h2);
    in_r = 4'h2;
    tick(1);
    chk_rd("rc_n_data", 0, 2'd0, 32'h0);
    tick(1);
    chk_rd("rc_n1_data", 0, 2'd0, 32'h2);
    chk_rd("rc_n1_cap", 0, 2'd3, 32'h0);
    chk_irq("rc_n1_irq", 0, 1'b0);
    tick(1);
    chk_rd("rc_n2_cap", 0, 2'd3, 32'h2);
    chk_irq("rc_n2_irq", 0, 1'b1);
    in_r = 4'h0;
    wr(4'b0001, 2'd3, 32'h2);
    chk_irq("rc_clr_irq", 0, 1'b0);
    chk_rd("rc_clr_cap", 0, 2'd3, 32'h0);

    // Masking.
    wr(4'b0001, 2'd2, 32'h0);
    in_r = 4'h1;
    tick(3);
    chk_rd("mask_cap", 0, 2'd3, 32'h1);
    chk_irq("mask_off_irq", 0, 1'b0);
    wr(4'b0001, 2'd2, 32'h1);
    chk_rd("mask_rd", 0, 2'd2, 32'h1);
    chk_irq("mask_on_irq", 0, 1'b1);

    // Edge on bit 2 coincides with a clear of bits 2 and 0.
    in_r = 4'h5;
    tick(2);
    wr(4'b0001, 2'd3, 32'h5);
    chk_rd("setclr_cap", 0, 2'd3, 32'h4);
    chk_irq("setclr_irq", 0, 1'b0);

    // Falling-edge instance.
    in_f = 4'hA;
    tick(4);
    chk_rd("fe_rise_cap", 3, 2'd3, 32'h0);
    chk_rd("fe_data", 3, 2'd0, 32'hA);
    in_f = 4'h0;
    tick(4);
    chk_rd("fe_fall_cap", 3, 2'd3, 32'hA);

    // Debounce D=8: short glitch rejected, long level accepted.
    wr(4'b0010, 2'd2, 32'h8);
    in_d = 4'h8;
    tick(5);
    in_d = 4'h0;
    tick(15);
    chk_rd("glitch_data", 1, 2'd0, 32'h0);
    chk_rd("glitch_cap", 1, 2'd3, 32'h0);
    chk_irq("glitch_irq", 1, 1'b0);
    in_d = 4'h8;
    tick(9);
    chk_rd("deb_n8_data", 1, 2'd0, 32'h0);
    tick(1);
    chk_rd("deb_n9_data", 1, 2'd0, 32'h8);
    chk_rd("deb_n9_cap", 1, 2'd3, 32'h0);
    tick(1);
    chk_rd("deb_n10_cap", 1, 2'd3, 32'h8);
    chk_irq("deb_irq", 1, 1'b1);
    tick(9);
    in_d = 4'h0;
    tick(12);
    chk_rd("deb_low_data", 1, 2'd0, 32'h0);
    chk_rd("deb_low_cap", 1, 2'd3, 32'h8);

    // Any-edge instance, plus ignored writes to addresses 0 and 1.
    in_a = 4'h1;
    tick(3);
    chk_rd("any_rise_cap", 2, 2'd3, 32'h1);
    wr(4'b0100, 2'd3, 32'h1);
    chk_rd("any_clr_cap", 2, 2'd3, 32'h0);
    in_a = 4'h0;
    tick(3);
    chk_rd("any_fall_cap", 2, 2'd3, 32'h1);
    wr(4'b0100, 2'd0, 32'hF);
    wr(4'b0100, 2'd1, 32'hF);
    chk_rd("ign_a0", 2, 2'd0, 32'h0);
    chk_rd("ign_a1", 2, 2'd1, 32'h0);
    chk_rd("ign_a2", 2, 2'd2, 32'h0);
    chk_rd("ign_a3", 2, 2'd3, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/final_project_soc_keys.md
# final_project_soc_keys

Avalon-MM slave input port with edge capture and interrupt. It samples the board push-buttons and switches (in_port), synchronizes and optionally debounces them, and latches selected edges into a software-clearable capture register. It raises a level interrupt to the Nios II processor when an unmasked capture bit is set. It sits on the same system interconnect as the LED output port and completes the input direction of the PIO pair.

## Interface

Parameters:
- WIDTH, 4: number of input bits, 1..32.
- EDGE_TYPE, 0: edge to capture. 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 0: consecutive stable samples required to accept a change. 0 = debounce bypassed. Legal range 0..65535.

Ports:
- clk, input, 1: system clock. All state is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- address, input, 2: register select. 0 = data, 1 = reserved, 2 = irq mask, 3 = edge capture.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe. A write occurs only when chipselect=1 and write_n=0.
- writedata, input, 32: write data. Only bits [WIDTH-1:0] are used.
- in_port, input, WIDTH: asynchronous external inputs.
- readdata, output, 32: combinational read data, zero-extended above WIDTH. Reset value 0.
- irq, output, 1: level interrupt. Reset value 0.

## Operation

- Synchronizer: two flops per bit. sync1 <= in_port; sync2 <= sync1.
- Debounce, when DEBOUNCE_CYCLES > 0: each bit has a 16-bit counter and a debounced value deb.
  - If sync2 == deb, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_CYCLES, deb takes sync2 and the counter clears.
  - When DEBOUNCE_CYCLES = 0, deb = sync2 with no extra register.
- Edge detect: prev <= deb every cycle.
  - rise = deb & ~prev.
  - fall = ~deb & prev.
  - The edge vector is selected by EDGE_TYPE; "any" is rise | fall.
- Edge capture register (cap): cap <= (cap & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] on a write to address 3, else 0 (write-1-to-clear).
  - A set in the same cycle as a clear of the same bit wins. No edge is lost.
- Mask register (mask): loaded from writedata[WIDTH-1:0] on a write to address 2.
- irq = |(cap & mask). It is driven from registers, so there is no glitch from the inputs.
- Reads are combinational, zero wait states, and have no side effects:
  - address 0 returns deb.
  - address 1 returns 0.
  - address 2 returns mask.
  - address 3 returns cap.
  - readdata is valid in the same cycle regardless of chipselect.
- Writes to addresses 0 and 1 are ignored.
- Reset clears sync1, sync2, deb, counters, prev, cap and mask to 0, asynchronously, including mid-debounce.
- An input held high through reset release produces one rising-edge capture after release.
  - mask is 0 after reset, so irq stays low.
  - Software clears cap before enabling the mask.

## Timing

- Cycle N is the first rising edge at which a new in_port level is stable.
- DEBOUNCE_CYCLES = 0:
  - sync2 and data read change after edge N+1.
  - cap bit and irq assert after edge N+2.
- DEBOUNCE_CYCLES = D > 0:
  - deb changes after edge N+1+D.
  - cap and irq assert after edge N+2+D.
- A glitch shorter than D cycles at sync2 never changes deb.
- Write to mask or cap: the register updates at that clock edge, and irq reflects it in the following cycle.
- Deasserting reset takes effect on the first clock edge after release. There is no reset synchronizer inside this block.

## Test plan

- Reset: assert reset mid-cycle with in_port=4'hF -> readdata=0 at all addresses and irq=0 immediately. After release, address 3 reads 4'hF two cycles later (rising edges) and irq stays 0.
- Rising capture, D=0: write mask=4'b0010, then pulse in_port[1] high at edge N -> address 0 reads 4'b0010 after N+1, address 3 reads 4'b0010 and irq=1 after N+2. Writing 32'h2 to address 3 -> irq=0 next cycle.
- Masking: capture bit 0 with mask=0 -> irq=0. Then write mask=4'b0001 -> irq=1 the next cycle.
- Simultaneous set/clear: a new edge on bit 2 lands in the same cycle as a write of 32'h4 to address 3 -> cap[2] remains 1.
- Debounce, D=8: a 5-cycle high glitch on in_port[3] -> no change at address 0 or 3. A 20-cycle high level -> deb[3] rises exactly 8 cycles after sync2 rises, and cap[3] is set one cycle later.
- EDGE_TYPE=2: toggle in_port[0] high, clear cap, then toggle low -> cap[0] is set on each transition. Writes to addresses 0 and 1 do not alter any readback.
